if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 93 +++++++++
 tb/tb_if_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the program counter, presents the fetch
// address to instruction SRAM and holds branch redirects that arrive while
// this stage is stalled. The redirect is applied on the first free cycle.
// Optional build macro: IF_ALIGN_CHECK_EN enables the misaligned-fetch check
// (fetch_adel). Without it, fetch_adel is tied low. The ports are the same in
// both builds.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        fetch_adel
);

  // Stall encoding shared with the rest of the pipeline.
  localparam logic STOP = 1'b1;

  // The pc resets one word below the boot vector. The first free cycle then
  // advances it onto 32'hBFC00000.
  localparam logic [31:0] PC_RESET = 32'hBFBFFFFC;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] next_pc;
  logic        fetch_ok;

  // Only bit 0 of the stall vector belongs to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Next-pc select. A live branch wins over a held redirect, and a held
  // redirect wins over sequential fetch.
  // NOTE: next_pc gets a value on every path. A missing branch in a
  // combinational block would infer a latch.
  always_comb begin
    next_pc = pc_r + 32'h4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (pend_v) begin
      next_pc = pend_addr;
    end
  end

  // pc / ce register plus the held-redirect register.
  // Reset is synchronous and overrides both stall and branch.
  // NOTE: state uses non-blocking assignments, so all registers update
  // together on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= PC_RESET;
      ce_r      <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'b0;
    end else if (stall[0] != STOP) begin
      pc_r   <= next_pc;
      ce_r   <= 1'b1;
      pend_v <= 1'b0;
    end else if (br_e) begin
      // While stalled, keep the latest redirect so it is not lost.
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Flag a word-misaligned fetch and suppress the SRAM access for it.
  assign fetch_adel = ce_r & (pc_r[1:0] != 2'b00);
`else
  assign fetch_adel = 1'b0;
`endif

  // SRAM request comes straight from the registers, with no added latency.
  // While stalled it repeats the same read.
  assign fetch_ok        = ce_r & ~fetch_adel;
  assign inst_sram_en    = fetch_ok;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_r;
  assign inst_sram_wdata = 32'b0;
  assign if_to_id_bus    = {fetch_ok, pc_r};

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. Each step drives one cycle of stimulus and
// queues the outputs expected after that clock edge. It then pops the queue
// and checks the outputs 1 ns after the edge.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_adel;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        en;
    logic        adel;
  } exp_t;

  exp_t sb_q[$];

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_adel      (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs,
                       input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against one scoreboard entry.
  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, e.addr});
    check({tag, ".en"},   {32'b0, inst_sram_en},  {32'b0, e.en});
    check({tag, ".bus"},  if_to_id_bus,           {e.en, e.addr});
    check({tag, ".adel"}, {32'b0, fetch_adel},    {32'b0, e.adel});
    check({tag, ".wen"},  {29'b0, inst_sram_wen}, 33'b0);
    check({tag, ".wdat"}, {1'b0, inst_sram_wdata}, 33'b0);
  endtask

  // Run one cycle: drive inputs, queue the expected result, clock, then
  // compare.
  task automatic step(input string tag, input logic r, input logic [5:0] st,
                      input logic be, input logic [31:0] ba,
                      input logic [31:0] ea, input logic ee, input logic ead);
    exp_t e;
    rst    = r;
    stall  = st;
    br_bus = {be, ba};
    sb_q.push_back('{addr: ea, en: ee, adel: ead});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  initial begin
    logic mis_en;
    logic mis_adel;
`ifdef IF_ALIGN_CHECK_EN
    mis_en   = 1'b0;
    mis_adel = 1'b1;
`else
    mis_en   = 1'b1;
    mis_adel = 1'b0;
`endif
    rst    = 1'b1;
    stall  = 6'b0;
    br_bus = 33'b0;

    // Reset is held for two cycles. The second cycle has a stall and a
    // branch, which reset must override.
    step("rst0", 1'b1, 6'd0, 1'b0, 32'h0,        32'hBFBFFFFC, 1'b0, 1'b0);
    step("rst1", 1'b1, 6'd1, 1'b1, 32'h12345678, 32'hBFBFFFFC, 1'b0, 1'b0);

    // First cycle after reset release: SRAM still disabled.
    rst = 1'b0;
    stall = 6'd0;
    br_bus = 33'b0;
    #1;
    compare_outputs("rel_c1", '{addr: 32'hBFBFFFFC, en: 1'b0, adel: 1'b0});
    step("rel_c2", 1'b0, 6'd0, 1'b0, 32'h0, 32'hBFC00000, 1'b1, 1'b0);
    step("rel_c3", 1'b0, 6'd0, 1'b0, 32'h0, 32'hBFC00004, 1'b1, 1'b0);
    step("rel_c4", 1'b0, 6'd0, 1'b0, 32'h0, 32'hBFC00008, 1'b1, 1'b0);

    // Redirect seen while addr=BFC00008.
    step("br_n1", 1'b0, 6'd0, 1'b1, 32'hBFC00100, 32'hBFC00100, 1'b1, 1'b0);
    step("br_n2", 1'b0, 6'd0, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0);

    // Branch in the first of three stall cycles.
    step("stb_s1", 1'b0, 6'd1, 1'b1, 32'h80001000, 32'hBFC00104, 1'b1, 1'b0);
    step("stb_s2", 1'b0, 6'd1, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0);
    step("stb_s3", 1'b0, 6'd1, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0);
    step("stb_f1", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80001000, 1'b1, 1'b0);
    step("stb_f2", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80001004, 1'b1, 1'b0);

    // Two branches in one stall: the later one wins.
    step("two_s1", 1'b0, 6'd1, 1'b1, 32'h80002000, 32'h80001004, 1'b1, 1'b0);
    step("two_s2", 1'b0, 6'd1, 1'b1, 32'h80003000, 32'h80001004, 1'b1, 1'b0);
    step("two_f1", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80003000, 1'b1, 1'b0);
    step("two_f2", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80003004, 1'b1, 1'b0);

    // Live branch in the release cycle overrides the held one. The held
    // redirect must then be cleared.
    step("ovr_s1", 1'b0, 6'd1, 1'b1, 32'h80004000, 32'h80003004, 1'b1, 1'b0);
    step("ovr_f1", 1'b0, 6'd0, 1'b1, 32'h80005000, 32'h80005000, 1'b1, 1'b0);
    step("ovr_f2", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80005004, 1'b1, 1'b0);

    // Reset during a stall discards the held redirect.
    step("rms_s1", 1'b0, 6'd1, 1'b1, 32'h80006000, 32'h80005004, 1'b1, 1'b0);
    step("rms_r",  1'b1, 6'd1, 1'b0, 32'h0,        32'hBFBFFFFC, 1'b0, 1'b0);
    step("rms_f1", 1'b0, 6'd0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 1'b0);

    // Stall bits other than bit 0 do not hold this stage.
    step("oth_st", 1'b0, 6'b111110, 1'b0, 32'h0,   32'hBFC00004, 1'b1, 1'b0);

    // The pc wraps from FFFFFFFC to 0.
    step("wrap1", 1'b0, 6'd0, 1'b1, 32'hFFFFFFFC,  32'hFFFFFFFC, 1'b1, 1'b0);
    step("wrap2", 1'b0, 6'd0, 1'b0, 32'h0,         32'h00000000, 1'b1, 1'b0);

    // Misaligned redirect. The expected outputs depend on the build.
    step("mis1", 1'b0, 6'd0, 1'b1, 32'h80000002, 32'h80000002, mis_en, mis_adel);
    step("mis2", 1'b0, 6'd0, 1'b0, 32'h0,        32'h80000006, mis_en, mis_adel);
    step("mis3", 1'b0, 6'd0, 1'b1, 32'h80000000, 32'h80000000, 1'b1,   1'b0);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
